sram_frame_sequencer: RTL and testbench
=======================================

// Module: sram_frame_sequencer
// PURPOSE
//  Upstream driver of the on-chip SRAM controller: buffers one byte frame into SRAM, then streams it back.
//  WRITE accepts a valid/ready byte stream and stores it at BASE_ADDR upward.
//  READ replays the stored frame in order on a valid/ready output.
//  Owns every SRAM control line (r_en, w_en, address, write_data); no other block drives the SRAM.
// PARAMETERS
//  ADDR_W     10   SRAM address width (bits)
//  DEPTH      1024 max frame length in bytes, 1..2**ADDR_W
//  BASE_ADDR  0    address of byte 0 of the frame
// PORTS
//  clk         in   1       system clock, rising edge
//  n_rst       in   1       asynchronous active-low reset
//  start_wr    in   1       1-cycle pulse: begin capturing a new frame (honoured only in IDLE)
//  start_rd    in   1       1-cycle pulse: replay the stored frame (honoured only in IDLE)
//  in_data     in   8       input byte
//  in_valid    in   1       input byte valid
//  in_last     in   1       marks the final byte of the frame; qualified by in_valid
//  in_ready    out  1       sequencer accepts the byte this cycle
//  out_data    out  8       replayed byte
//  out_valid   out  1       replayed byte valid
//  out_ready   in   1       downstream accepts out_data
//  sram_r_en   out  1       SRAM read enable
//  sram_w_en   out  1       SRAM write enable
//  sram_addr   out  ADDR_W  SRAM address
//  sram_wdata  out  8       SRAM write data
//  sram_rdata  in   8       SRAM read data; valid the cycle after sram_r_en
//  frame_len   out  ADDR_W+1  length of the stored frame in bytes
//  busy        out  1       high in any state other than IDLE
//  done        out  1       1-cycle pulse when a WRITE or READ operation completes
//  overflow    out  1       sticky: last frame was truncated at DEPTH
// BEHAVIOUR
//  Reset: state IDLE; every output 0; frame_len 0.
//  States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD.
//  Start pulses: both asserted in IDLE -> start_wr wins. Both ignored when not in IDLE.
//  IDLE->WRITE on start_wr:
//   - frame_len <= 0, overflow <= 0.
//   - Address counter loaded with BASE_ADDR.
//  WRITE: in_ready = 1 while count < DEPTH.
//   - Handshake (in_valid & in_ready) at cycle N. At N+1 the registered outputs give:
//     sram_w_en = 1, sram_addr = BASE_ADDR + count, sram_wdata = in_data.
//   - The handshake also increments count. One byte per cycle is sustained.
//  Leaving WRITE:
//   - Byte accepted with in_last -> IDLE. done pulses in the cycle that byte's w_en is high.
//   - count reaches DEPTH without in_last -> in_ready drops; overflow <= 1; go to IDLE; done pulses.
//   - frame_len <= count when leaving WRITE.
//  IDLE->RD_ISSUE on start_rd: read index <= 0. If frame_len == 0, done pulses next cycle, return to IDLE, no r_en.
//  RD_ISSUE:
//   - sram_r_en = 1 and sram_addr = BASE_ADDR + idx for exactly 1 cycle.
//   - Then RD_WAIT.
//  RD_WAIT: capture sram_rdata into out_data; out_valid <= 1; go to RD_HOLD.
//  RD_HOLD: hold out_data stable while out_valid & !out_ready. On accept:
//   - idx+1 == frame_len -> out_valid <= 0, done pulses, IDLE.
//   - otherwise -> idx++, RD_ISSUE.
//  Read throughput: at most one byte every 3 cycles. Only one read is outstanding at a time.
//  r_en and w_en are never high together. Both are 0 in IDLE.
//  Address arithmetic is modulo 2**ADDR_W: BASE_ADDR + DEPTH - 1 wraps silently.
//  Reset mid-operation: immediate return to IDLE, outputs cleared, stored frame_len lost.
// STRUCTURE
//  Package sram_seq_pkg holds:
//   - typedef enum seq_state_t {IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD}.
//   - Default constants for ADDR_W and DEPTH.
//  Sub-module sram_addr_counter:
//   - Loadable, enabled counter: ADDR_W+1-bit count plus the offset address.
//   - Shared by the write count and the read index.
//  Top level holds the FSM, the output registers and the valid/ready logic.
// TESTING
//  1 start_wr; 4 bytes 11,22,33,44 back-to-back, last on 44 ->
//    w_en on 4 consecutive cycles at addr 0..3; frame_len 4; done once; overflow 0.
//  2 After test 1, start_rd with out_ready = 1 -> out_data 11,22,33,44 in order;
//    one r_en per byte; done after 44; busy drops.
//  3 Read backpressure: out_ready = 0 for 5 cycles on byte 2 -> out_data holds 22; no new r_en until accept.
//  4 DEPTH=4, stream 6 bytes without last -> in_ready low after 4th; overflow = 1; frame_len 4.
//  5 start_wr and start_rd in the same cycle -> WRITE entered; start_rd while busy ignored;
//    start_rd with frame_len 0 -> done, no r_en.
//  6 n_rst asserted in RD_HOLD -> all outputs 0 asynchronously; IDLE; frame_len 0.

Source files
------------

// File: rtl/sram_seq_pkg.sv
// Shared types and default sizing for the SRAM frame sequencer.
package sram_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD
    } seq_state_t;

    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_DEPTH     = 1024;
    localparam int DEF_BASE_ADDR = 0;

endpackage

// File: rtl/sram_frame_sequencer_if.sv
// Byte-stream and SRAM bus bundle of the frame sequencer.
// master: the sequencer side; slave: upstream source, downstream sink and SRAM.
interface sram_frame_sequencer_if
    import sram_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              sram_r_en;
    logic              sram_w_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [7:0]        sram_wdata;
    logic [7:0]        sram_rdata;

    modport master (
        input  in_data, in_valid, in_last, out_ready, sram_rdata,
        output in_ready, out_data, out_valid, sram_r_en, sram_w_en, sram_addr, sram_wdata
    );

    modport slave (
        output in_data, in_valid, in_last, out_ready, sram_rdata,
        input  in_ready, out_data, out_valid, sram_r_en, sram_w_en, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_addr_counter.sv
// Loadable byte counter shared by the write count and the read index.
// addr is the SRAM address of the current byte, wrapping modulo 2**ADDR_W.
module sram_addr_counter #(
    parameter int                ADDR_W = 10,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              load,
    input  logic              en,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] addr
);

    // Count register: load restarts the frame at byte 0, en advances one byte.
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!n_rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + (ADDR_W+1)'(1);
        end
    end

    assign addr = BASE + count[ADDR_W-1:0];

endmodule

// File: rtl/sram_frame_sequencer.sv
// Buffers one byte frame into SRAM, then replays it in order.
// Sole driver of the SRAM control lines; one read outstanding at a time.
module sram_frame_sequencer
    import sram_seq_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start_wr,
    input  logic                  start_rd,
    sram_frame_sequencer_if.master bus,
    output logic [ADDR_W:0]       frame_len,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   ONE      = (ADDR_W+1)'(1);

    seq_state_t        state_q, state_d;

    logic [ADDR_W:0]   cnt;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_load, cnt_en;

    logic              in_ready_c;
    logic              go_wr, go_rd, rd_empty;
    logic              wr_fire, wr_last, wr_trunc;
    logic              rd_accept, rd_last;
    logic [ADDR_W-1:0] rd_addr_next;

    logic              w_en_q, r_en_q, done_q, overflow_q, out_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q, out_data_q;
    logic [ADDR_W:0]   frame_len_q;

    sram_addr_counter #(
        .ADDR_W (ADDR_W),
        .BASE   (BASE)
    ) u_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .load  (cnt_load),
        .en    (cnt_en),
        .count (cnt),
        .addr  (cnt_addr)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: write until last byte or DEPTH, read as issue/wait/hold per byte.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (go_wr) begin
                    state_d = WRITE;
                end else if (go_rd) begin
                    state_d = RD_ISSUE;
                end
            end
            WRITE: begin
                if (wr_last || wr_trunc) begin
                    state_d = IDLE;
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  state_d = RD_HOLD;
            RD_HOLD: begin
                if (rd_last) begin
                    state_d = IDLE;
                end else if (rd_accept) begin
                    state_d = RD_ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: handshakes, start qualification and counter control.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        in_ready_c = 1'b0;
        go_wr      = 1'b0;
        go_rd      = 1'b0;
        rd_empty   = 1'b0;
        wr_fire    = 1'b0;
        wr_last    = 1'b0;
        wr_trunc   = 1'b0;
        rd_accept  = 1'b0;
        rd_last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                go_wr    = start_wr;
                go_rd    = !start_wr && start_rd && (frame_len_q != '0);
                rd_empty = !start_wr && start_rd && (frame_len_q == '0);
            end
            WRITE: begin
                in_ready_c = (cnt < DEPTH_C);
                wr_fire    = bus.in_valid && in_ready_c;
                wr_last    = wr_fire && bus.in_last;
                wr_trunc   = wr_fire && !bus.in_last && (cnt == LAST_IDX);
            end
            RD_HOLD: begin
                rd_accept = bus.out_ready;
                rd_last   = rd_accept && (cnt == frame_len_q - ONE);
            end
            default: ;
        endcase
        cnt_load     = go_wr || go_rd;
        cnt_en       = wr_fire || (rd_accept && !rd_last);
        rd_addr_next = (state_q == IDLE) ? BASE : cnt_addr + ADDR_W'(1);
    end

    // Registered outputs: SRAM strobes and address, replay byte, status flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            w_en_q      <= 1'b0;
            r_en_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            out_data_q  <= '0;
            frame_len_q <= '0;
        end else begin
            w_en_q <= wr_fire;
            r_en_q <= (state_d == RD_ISSUE);
            done_q <= wr_last || wr_trunc || rd_last || rd_empty;

            if (wr_fire) begin
                addr_q  <= cnt_addr;
                wdata_q <= bus.in_data;
            end else if (state_d == RD_ISSUE) begin
                addr_q <= rd_addr_next;
            end

            if (go_wr) begin
                frame_len_q <= '0;
                overflow_q  <= 1'b0;
            end else if (wr_last || wr_trunc) begin
                frame_len_q <= cnt + ONE;
                overflow_q  <= wr_trunc;
            end

            // A replayed byte is valid only in RD_HOLD; it drops on every accept.
            if (state_q == RD_WAIT) begin
                out_data_q  <= bus.sram_rdata;
                out_valid_q <= 1'b1;
            end else if (rd_accept) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.sram_r_en  = r_en_q;
    assign bus.sram_w_en  = w_en_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign frame_len      = frame_len_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_sram_frame_sequencer.sv
// Self-checking bench for sram_frame_sequencer: small SRAM, DEPTH 4, base 6 so addresses wrap.
module tb_sram_frame_sequencer;

    localparam int ADDR_W    = 3;
    localparam int DEPTH     = 4;
    localparam int BASE_ADDR = 6;
    localparam int SIZE      = 1 << ADDR_W;

    typedef logic [7:0] byte_q_t[$];
    typedef enum {PH_IDLE, PH_WRITE, PH_READ} phase_t;

    logic            clk      = 1'b0;
    logic            n_rst    = 1'b1;
    logic            start_wr = 1'b0;
    logic            start_rd = 1'b0;
    logic [ADDR_W:0] frame_len;
    logic            busy, done, overflow;

    sram_frame_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    sram_frame_sequencer #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start_wr  (start_wr),
        .start_rd  (start_rd),
        .bus       (bus),
        .frame_len (frame_len),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // SRAM: write on w_en, read data one cycle after r_en.
    logic [7:0] mem [SIZE];
    always @(posedge clk) begin
        if (bus.sram_w_en) mem[bus.sram_addr] <= bus.sram_wdata;
        if (bus.sram_r_en) bus.sram_rdata <= mem[bus.sram_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Behavioural model: frame contents, write count, read index and cycles since issue.
    phase_t            m_phase = PH_IDLE;
    int                m_cnt = 0, m_len = 0, rd_idx = 0, rd_t = 0;
    bit                m_ovf = 0, exp_w = 0, exp_done = 0;
    logic [ADDR_W-1:0] exp_w_addr;
    logic [7:0]        exp_w_data;
    logic [7:0]        m_frame [DEPTH];

    // Observation logs read by the directed tests.
    int         done_cnt = 0, r_cnt = 0;
    int         w_addr_log[$];
    longint     w_cyc_log[$];
    logic [7:0] out_log[$];
    longint     cyc = 0;

    function automatic logic [ADDR_W-1:0] wrap_addr(input int idx);
        return ADDR_W'((BASE_ADDR + idx) % SIZE);
    endfunction

    // Compare process: check every output each cycle, then advance the model on sampled inputs.
    always @(negedge clk) begin
        cyc++;
        if (!n_rst) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_frame_len", frame_len, 0);
            check("rst_overflow", overflow, 0);
            check("rst_w_en", bus.sram_w_en, 0);
            check("rst_r_en", bus.sram_r_en, 0);
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_in_ready", bus.in_ready, 0);
            m_phase  = PH_IDLE;
            m_len    = 0;
            m_ovf    = 0;
            exp_w    = 0;
            exp_done = 0;
        end else begin
            check("busy", busy, m_phase != PH_IDLE);
            check("in_ready", bus.in_ready, m_phase == PH_WRITE && m_cnt < DEPTH);
            check("w_en", bus.sram_w_en, exp_w);
            if (exp_w) begin
                check("w_addr", bus.sram_addr, exp_w_addr);
                check("w_data", bus.sram_wdata, exp_w_data);
            end
            check("r_en", bus.sram_r_en, m_phase == PH_READ && rd_t == 0);
            if (m_phase == PH_READ && rd_t == 0) check("r_addr", bus.sram_addr, wrap_addr(rd_idx));
            check("out_valid", bus.out_valid, m_phase == PH_READ && rd_t >= 2);
            if (m_phase == PH_READ && rd_t >= 2) check("out_data", bus.out_data, m_frame[rd_idx]);
            check("done", done, exp_done);
            check("overflow", overflow, m_ovf);
            check("frame_len", frame_len, m_len);

            if (bus.sram_w_en) begin
                w_addr_log.push_back(int'(bus.sram_addr));
                w_cyc_log.push_back(cyc);
            end
            if (bus.sram_r_en) r_cnt++;
            if (done) done_cnt++;
            if (bus.out_valid && bus.out_ready) out_log.push_back(bus.out_data);

            exp_w    = 0;
            exp_done = 0;
            case (m_phase)
                PH_IDLE: begin
                    if (start_wr) begin
                        m_phase = PH_WRITE;
                        m_cnt   = 0;
                        m_len   = 0;
                        m_ovf   = 0;
                    end else if (start_rd) begin
                        if (m_len == 0) begin
                            exp_done = 1;
                        end else begin
                            m_phase = PH_READ;
                            rd_idx  = 0;
                            rd_t    = 0;
                        end
                    end
                end
                PH_WRITE: begin
                    if (bus.in_valid && m_cnt < DEPTH) begin
                        exp_w          = 1;
                        exp_w_addr     = wrap_addr(m_cnt);
                        exp_w_data     = bus.in_data;
                        m_frame[m_cnt] = bus.in_data;
                        m_cnt++;
                        if (bus.in_last) begin
                            m_len    = m_cnt;
                            exp_done = 1;
                            m_phase  = PH_IDLE;
                        end else if (m_cnt == DEPTH) begin
                            m_len    = m_cnt;
                            m_ovf    = 1;
                            exp_done = 1;
                            m_phase  = PH_IDLE;
                        end
                    end
                end
                PH_READ: begin
                    if (rd_t >= 2 && bus.out_ready) begin
                        if (rd_idx + 1 == m_len) begin
                            exp_done = 1;
                            m_phase  = PH_IDLE;
                        end else begin
                            rd_idx++;
                            rd_t = 0;
                        end
                    end else if (rd_t < 2) begin
                        rd_t++;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit wr, input bit rd);
        start_wr = wr;
        start_rd = rd;
        tick();
        start_wr = 0;
        start_rd = 0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60; i++) begin
            if (!busy) return;
            tick();
        end
        timeout(name);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) return;
            tick();
        end
        timeout(name);
    endtask

    // Offer bytes one at a time; stop early once the sequencer closes the frame.
    task automatic send_frame(input byte_q_t data, input bit use_last, input bit gaps);
        bit ok;
        for (int i = 0; i < data.size(); i++) begin
            if (!busy) break;
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 0;
                start_rd     = 1'($urandom_range(0, 1));
                start_wr     = 1'($urandom_range(0, 1));
                tick();
                start_rd     = 0;
                start_wr     = 0;
            end
            bus.in_data  = data[i];
            bus.in_last  = use_last && (i == data.size() - 1);
            bus.in_valid = 1;
            ok = 0;
            for (int w = 0; w < 16; w++) begin
                if (bus.in_ready) begin
                    tick();
                    ok = 1;
                    break;
                end
                tick();
            end
            if (!ok) begin
                timeout("in_ready_wait");
                break;
            end
        end
        bus.in_valid = 0;
        bus.in_last  = 0;
    endtask

    task automatic read_frame(input bit bp);
        bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        pulse_start(0, 1);
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin
                bus.out_ready = 1;
                return;
            end
            bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        timeout("read_done_wait");
        bus.out_ready = 1;
    endtask

    initial begin
        byte_q_t q;
        int      wb, db, rb, ob, r_hold, n;
        bit      use_last;

        bus.in_data   = 0;
        bus.in_valid  = 0;
        bus.in_last   = 0;
        bus.out_ready = 1;

        // Reset state.
        #2 n_rst = 0;
        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_frame_len", frame_len, 0);
        check("reset_out_data", bus.out_data, 0);
        check("reset_sram_addr", bus.sram_addr, 0);
        n_rst = 1;
        tick();

        // 1: four bytes back to back, last on 44.
        wb = w_addr_log.size();
        db = done_cnt;
        pulse_start(1, 0);
        q = {8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(q, 1, 0);
        wait_idle("t1_idle");
        tick();
        check("t1_w_count", w_addr_log.size() - wb, 4);
        check("t1_addr0", w_addr_log[wb], 6);
        check("t1_addr1", w_addr_log[wb+1], 7);
        check("t1_addr2", w_addr_log[wb+2], 0);
        check("t1_addr3", w_addr_log[wb+3], 1);
        check("t1_w_consecutive", 32'(w_cyc_log[wb+3] - w_cyc_log[wb]), 3);
        check("t1_frame_len", frame_len, 4);
        check("t1_overflow", overflow, 0);
        check("t1_done_count", done_cnt - db, 1);

        // 2: full replay with no backpressure.
        ob = out_log.size();
        rb = r_cnt;
        db = done_cnt;
        read_frame(0);
        tick();
        check("t2_out_count", out_log.size() - ob, 4);
        check("t2_out0", out_log[ob], 8'h11);
        check("t2_out1", out_log[ob+1], 8'h22);
        check("t2_out2", out_log[ob+2], 8'h33);
        check("t2_out3", out_log[ob+3], 8'h44);
        check("t2_r_en_count", r_cnt - rb, 4);
        check("t2_done_count", done_cnt - db, 1);
        check("t2_busy", busy, 0);

        // 3: hold byte 2 for five cycles.
        ob = out_log.size();
        rb = r_cnt;
        bus.out_ready = 0;
        pulse_start(0, 1);
        wait_valid("t3_valid0");
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        wait_valid("t3_valid1");
        r_hold = r_cnt;
        repeat (5) begin
            check("t3_hold_data", bus.out_data, 8'h22);
            check("t3_hold_valid", bus.out_valid, 1);
            tick();
        end
        check("t3_hold_no_r_en", r_cnt - r_hold, 0);
        bus.out_ready = 1;
        wait_idle("t3_idle");
        tick();
        check("t3_out1", out_log[ob+1], 8'h22);
        check("t3_out3", out_log[ob+3], 8'h44);
        check("t3_r_en_count", r_cnt - rb, 4);

        // 4: six bytes without last into a 4-byte frame.
        wb = w_addr_log.size();
        db = done_cnt;
        pulse_start(1, 0);
        q = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        send_frame(q, 0, 0);
        wait_idle("t4_idle");
        tick();
        check("t4_w_count", w_addr_log.size() - wb, 4);
        check("t4_frame_len", frame_len, 4);
        check("t4_overflow", overflow, 1);
        check("t4_in_ready", bus.in_ready, 0);
        check("t4_done_count", done_cnt - db, 1);
        ob = out_log.size();
        read_frame(1);
        tick();
        check("t4_out0", out_log[ob], 8'hA0);
        check("t4_out3", out_log[ob+3], 8'hA3);
        check("t4_overflow_sticky", overflow, 1);

        // 5: both starts together, start_rd while busy.
        rb = r_cnt;
        pulse_start(1, 1);
        check("t5_busy", busy, 1);
        check("t5_in_ready", bus.in_ready, 1);
        check("t5_overflow_cleared", overflow, 0);
        pulse_start(0, 1);
        q = {8'h5A, 8'hA5};
        send_frame(q, 1, 0);
        wait_idle("t5_idle");
        tick();
        check("t5_no_r_en", r_cnt - rb, 0);
        check("t5_frame_len", frame_len, 2);

        // Randomized writes and reads.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                n        = $urandom_range(1, 6);
                use_last = (n <= DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
                q.delete();
                for (int k = 0; k < n; k++) q.push_back(8'($urandom));
                pulse_start(1, 1'($urandom_range(0, 1)));
                send_frame(q, use_last, 1);
                wait_idle("rand_write_idle");
            end else begin
                read_frame(1);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        // 6: reset while holding a replayed byte.
        pulse_start(1, 0);
        q = {8'h01, 8'h02, 8'h03};
        send_frame(q, 1, 0);
        wait_idle("t6_write_idle");
        bus.out_ready = 0;
        pulse_start(0, 1);
        wait_valid("t6_valid");
        #2 n_rst = 0;
        #1;
        check("t6_out_valid", bus.out_valid, 0);
        check("t6_out_data", bus.out_data, 0);
        check("t6_busy", busy, 0);
        check("t6_frame_len", frame_len, 0);
        check("t6_sram_addr", bus.sram_addr, 0);
        tick();
        n_rst = 1;
        bus.out_ready = 1;
        tick();

        // Empty-frame read: done next cycle, no r_en.
        rb = r_cnt;
        db = done_cnt;
        pulse_start(0, 1);
        check("t6_empty_done", done, 1);
        tick();
        tick();
        check("t6_empty_done_count", done_cnt - db, 1);
        check("t6_empty_no_r_en", r_cnt - rb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
